mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit sequencing the shared CPU datapath (single memory port, single ALU, 8×16-bit register file) through fetch/decode/execute/memory/write-back steps. It replaces the single-cycle combinational decoder: one instruction occupies 3–5 clock cycles, and all datapath enables come from one Moore state machine. It sits inside `CPU` between the instruction register fields and the datapath muxes and enables.

## Interface
- No parameters; widths fixed by the ISA.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: run enable, level-sensitive.
- `Op` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag.
- `PCEn` out 1: PC load = `PCWrite | (PCWriteCond & Zero)`.
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: write register select, 1 = rd, 0 = rt.
- `MemtoReg` out 1: write-back data select, 1 = MDR.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A select, 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU B select, 00 = B, 01 = const 1, 10 = sign-extended immediate, 11 = sign-extended immediate used as branch offset.
- `ALUCtl` out 3: ALU operation, 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `PCSource` out 2: PC source select, 00 = ALU, 01 = ALUOut, 10 = jump target.
- `Busy` out 1: high whenever the FSM is not in IDLE or HALT.
- `Halt` out 1: high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, HALT.
- Transitions:
  - IDLE → FETCH when `START` = 1.
  - FETCH → DECODE.
  - DECODE dispatches on `Op`:
    - 000000 (R-type) → EXEC.
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - Any other opcode → HALT.
    - R-type with `Funct` not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} → HALT.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - EXEC → ALUWB.
  - Terminal states MEMWB, MEMWR, ALUWB, BRANCH, JUMP → FETCH if `START` = 1, else → IDLE.
  - HALT is sticky until `RST_N` is asserted.
- Per-state outputs. Any output not listed is 0; ALUCtl defaults to ADD.
  - FETCH: IRWrite = 1, PCWrite = 1, ALUSrcB = 01, ALUCtl = ADD.
  - DECODE: ALUSrcB = 11, ALUCtl = ADD (branch target into ALUOut).
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUCtl = ADD.
  - MEMRD: IorD = 1.
  - MEMWB: MemtoReg = 1, RegWrite = 1, RegDst = 0.
  - MEMWR: IorD = 1, MemWrite = 1.
  - EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUCtl from `Funct` (add→010, sub→110, and→000, or→001, slt→111).
  - ALUWB: RegDst = 1, RegWrite = 1.
  - BRANCH: ALUSrcA = 1, ALUCtl = SUB, PCSource = 01, PCWriteCond = 1.
  - JUMP: PCSource = 10, PCWrite = 1.
- `START` is sampled only in IDLE and in terminal states. Deasserting it mid-instruction finishes the current instruction and then stops; no partial instruction is ever abandoned.

## Timing
- Reset: state = IDLE; every output = 0 (ALUCtl = 000). Reset mid-instruction aborts immediately and the next instruction restarts at FETCH.
- All outputs except `PCEn` decode from registered state only. `PCEn` is combinational on `Zero` in BRANCH.
- Latency from FETCH entry to the next FETCH:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
- Startup: the first FETCH occurs the cycle after `START` is sampled high in IDLE.
- Write commit: RegWrite/MemWrite commit at the rising edge that ends MEMWB/ALUWB/MEMWR.

## Configuration
- `MC_CTRL_PERF_EN`: when defined, adds outputs `CycleCnt` [15:0] and `InstrCnt` [15:0].
  - `CycleCnt` increments each cycle while `Busy` is high.
  - `InstrCnt` increments on each terminal-state exit.
  - Both counters wrap at 16'hFFFF → 0 and reset to 0.
- When not defined, neither the ports nor the counter logic exist.

## Structure
- Package `mc_pkg`: state enum, opcode constants, funct constants, ALUCtl codes, ALUSrcB/PCSource encodings.
- Sub-module `alu_dec`: combinational Funct → {ALUCtl, legal}, used by EXEC output decode and the DECODE illegal check.

## Test plan
- Reset with `START` = 0 → IDLE, all outputs 0, `Busy` = 0 indefinitely.
- `START` = 1, add (Op 000000, Funct 100000) → FETCH, DECODE, EXEC (ALUCtl = 010), ALUWB (RegWrite = 1, RegDst = 1); 4 cycles; next state FETCH.
- lw then sw → lw takes 5 cycles with IorD = 1 in MEMRD and MemtoReg = 1 in MEMWB; sw takes 4 cycles with MemWrite pulsing for exactly 1 cycle.
- beq, `Zero` = 1 vs `Zero` = 0 → `PCEn` = 1 vs 0 in the BRANCH cycle; PCSource = 01 in both cases.
- Op 111111, or Funct 000000 on an R-type → HALT after DECODE, `Halt` = 1, stays in HALT with `START` high; `RST_N` pulse → IDLE.
- `START` dropped during EXEC → ALUWB still completes, then IDLE. `RST_N` asserted during MEMRD → outputs 0 at once. With `MC_CTRL_PERF_EN` defined: 3 add instructions → `InstrCnt` = 3, `CycleCnt` = 12.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and ISA encodings for the multi-cycle controller.
// Imported by mc_ctrl and alu_dec.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Terminal states are the only places START is re-sampled after IDLE.
  function automatic logic is_terminal(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/alu_dec.sv
// R-type function decoder: maps Funct to an ALU operation and flags
// function codes the datapath cannot execute.
module alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl,
  output logic       legal
);

  always_comb begin
    alu_ctl = ALU_ADD;
    legal   = 1'b1;
    case (funct)
      FUNCT_ADD: alu_ctl = ALU_ADD;
      FUNCT_SUB: alu_ctl = ALU_SUB;
      FUNCT_AND: alu_ctl = ALU_AND;
      FUNCT_OR:  alu_ctl = ALU_OR;
      FUNCT_SLT: alu_ctl = ALU_SLT;
      default:   legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Moore-style multi-cycle control FSM for the shared-datapath CPU.
// Optional MC_CTRL_PERF_EN adds busy-cycle and retired-instruction counters.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtl,
  output logic [1:0] PCSource,
  output logic       Busy,
  output logic       Halt
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [15:0] CycleCnt,
  output logic [15:0] InstrCnt
`endif
);

  state_t     state;
  state_t     state_next;
  logic [2:0] funct_ctl;
  logic       funct_legal;
  logic       pc_write;
  logic       pc_write_cond;

  alu_dec u_alu_dec (
    .funct   (Funct),
    .alu_ctl (funct_ctl),
    .legal   (funct_legal)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (START) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     state_next = funct_legal ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_HALT;
        endcase
      end
      // The IR is only reloaded in FETCH, so Op still names lw/sw here.
      S_MEMADR: state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = S_ALUWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP:
        state_next = START ? S_FETCH : S_IDLE;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    IorD          = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    ALUCtl        = ALU_ADD;
    PCSource      = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (state)
      S_IDLE, S_HALT: ALUCtl = ALU_AND;
      S_FETCH: begin
        IRWrite  = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = SRCB_ONE;
      end
      S_DECODE: ALUSrcB = SRCB_BOFF;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtl  = funct_ctl;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUCtl        = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // PCEn is the one output allowed to follow the ALU flag within the cycle.
  assign PCEn = pc_write | (pc_write_cond & Zero);
  assign Busy = (state != S_IDLE) && (state != S_HALT);
  assign Halt = (state == S_HALT);

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CycleCnt <= 16'd0;
      InstrCnt <= 16'd0;
    end else begin
      if (Busy)               CycleCnt <= CycleCnt + 16'd1;
      if (is_terminal(state)) InstrCnt <= InstrCnt + 16'd1;
    end
  end
`endif

endmodule
